// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with load extraction and writeback select.
// Drives the register-file write port from registered state and counts retired instructions.
module mem_wb_writeback #(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic                 in_RegWrite,
    input  logic [1:0]           in_result_sel,
    input  logic [2:0]           in_funct3,
    input  logic [4:0]           in_rd,
    input  logic [XLEN-1:0]      in_alu_result,
    input  logic [XLEN-1:0]      in_mem_rdata,
    input  logic [XLEN-1:0]      in_pc_plus4,
    output logic                 RegWrite,
    output logic [4:0]           WriteReg,
    output logic [XLEN-1:0]      WriteData,
    output logic                 wb_valid,
    output logic                 illegal_load,
    output logic [INSTRET_W-1:0] instret
);

    localparam int unsigned RD_W  = 5;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] SEL_ALU  = 2'd0;
    localparam logic [SEL_W-1:0] SEL_LOAD = 2'd1;
    localparam logic [SEL_W-1:0] SEL_LINK = 2'd2;

    logic                 wb_valid_q,  wb_valid_d;
    logic                 reg_write_q, reg_write_d;
    logic                 illegal_q,   illegal_d;
    logic [RD_W-1:0]      write_reg_q, write_reg_d;
    logic [XLEN-1:0]      write_data_q, write_data_d;
    logic [INSTRET_W-1:0] instret_q,   instret_d;

    logic [2:0]      off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [31:0]     ld_word;
    logic [XLEN-1:0] load_data;
    logic            load_illegal;
    logic [XLEN-1:0] wb_data;
    logic            sel_writes;

    // Pick the addressed lane out of the aligned doubleword
    always_comb begin
        off     = in_alu_result[2:0];
        ld_byte = in_mem_rdata[{off, 3'b000} +: 8];
        ld_half = in_mem_rdata[{off[2:1], 4'b0000} +: 16];
        ld_word = in_mem_rdata[{off[2], 5'b00000} +: 32];
    end

    always_comb begin
        load_data    = '0;
        load_illegal = 1'b0;
        case (in_funct3)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            3'b010:  load_data = {{(XLEN-32){ld_word[31]}}, ld_word};
            3'b110:  load_data = {{(XLEN-32){1'b0}}, ld_word};
            3'b011:  load_data = in_mem_rdata;
            default: load_illegal = 1'b1;
        endcase
    end

    // Writeback value; the reserved select and an illegal load suppress the write
    always_comb begin
        wb_data    = '0;
        sel_writes = 1'b1;
        case (in_result_sel)
            SEL_ALU:  wb_data = in_alu_result;
            SEL_LOAD: begin
                wb_data    = load_data;
                sel_writes = ~load_illegal;
            end
            SEL_LINK: wb_data = in_pc_plus4;
            default:  sel_writes = 1'b0;
        endcase
    end

    always_comb begin
        wb_valid_d   = wb_valid_q;
        reg_write_d  = reg_write_q;
        illegal_d    = illegal_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        instret_d    = instret_q;
        if (flush) begin
            wb_valid_d   = 1'b0;
            reg_write_d  = 1'b0;
            illegal_d    = 1'b0;
            write_reg_d  = '0;
            write_data_d = '0;
        end else if (!stall) begin
            wb_valid_d   = in_valid;
            illegal_d    = in_valid & (in_result_sel == SEL_LOAD) & load_illegal;
            reg_write_d  = in_valid & in_RegWrite & sel_writes & (in_rd != '0);
            write_reg_d  = in_rd;
            write_data_d = wb_data;
            if (in_valid) begin
                instret_d = instret_q + INSTRET_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid_q   <= 1'b0;
            reg_write_q  <= 1'b0;
            illegal_q    <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            instret_q    <= '0;
        end else begin
            wb_valid_q   <= wb_valid_d;
            reg_write_q  <= reg_write_d;
            illegal_q    <= illegal_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            instret_q    <= instret_d;
        end
    end

    // x0 and bubbles are already folded into reg_write_q at capture
    assign RegWrite     = reg_write_q;
    assign WriteReg     = write_reg_q;
    assign WriteData    = write_data_q;
    assign wb_valid     = wb_valid_q;
    assign illegal_load = illegal_q;
    assign instret      = instret_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Randomized and directed checks of mem_wb_writeback against a behavioural model.
module tb_mem_wb_writeback;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, stall, flush, in_valid, in_RegWrite;
    logic [1:0]  in_result_sel;
    logic [2:0]  in_funct3;
    logic [4:0]  in_rd;
    logic [63:0] in_alu_result, in_mem_rdata, in_pc_plus4;

    logic        RegWrite, wb_valid, illegal_load;
    logic [4:0]  WriteReg;
    logic [63:0] WriteData, instret;

    logic        s_RegWrite, s_wb_valid, s_illegal_load;
    logic [4:0]  s_WriteReg;
    logic [63:0] s_WriteData;
    logic [3:0]  s_instret;

    mem_wb_writeback dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_RegWrite(in_RegWrite), .in_result_sel(in_result_sel), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_pc_plus4(in_pc_plus4), .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData), .wb_valid(wb_valid), .illegal_load(illegal_load),
        .instret(instret)
    );

    // Narrow counter instance so wraparound is reachable in a short run
    mem_wb_writeback #(.INSTRET_W(4)) dut_s (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .in_RegWrite(in_RegWrite), .in_result_sel(in_result_sel), .in_funct3(in_funct3),
        .in_rd(in_rd), .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata),
        .in_pc_plus4(in_pc_plus4), .RegWrite(s_RegWrite), .WriteReg(s_WriteReg),
        .WriteData(s_WriteData), .wb_valid(s_wb_valid), .illegal_load(s_illegal_load),
        .instret(s_instret)
    );

    int checks = 0;
    int errors = 0;

    logic        m_v, m_rw, m_ill;
    logic [4:0]  m_rd;
    logic [63:0] m_wd, m_ins;

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] addr,
                                             input logic [63:0] d);
        int size, off, lane;
        logic [63:0] mask, v;
        if (f3 == 3'b111) return 64'd0;
        size = 1 << f3[1:0];
        off  = int'(addr[2:0]);
        lane = off - (off % size);
        mask = (size == 8) ? {64{1'b1}} : ((64'd1 << (8 * size)) - 64'd1);
        v    = (d >> (8 * lane)) & mask;
        if (!f3[2] && v[8 * size - 1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [135:0] model_vec();
        return {m_rw, m_rd, m_wd, m_v, m_ill, m_ins};
    endfunction

    function automatic logic [135:0] dut_vec();
        return {RegWrite, WriteReg, WriteData, wb_valid, illegal_load, instret};
    endfunction

    // Apply one cycle of inputs, advance the model, sample 1ns after the edge
    task automatic step(input logic r, input logic f, input logic s, input logic v,
                        input logic rw, input logic [1:0] sel, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [63:0] alu, input logic [63:0] mem,
                        input logic [63:0] pc);
        logic [63:0] val;
        logic        ill;
        rst = r; flush = f; stall = s; in_valid = v; in_RegWrite = rw;
        in_result_sel = sel; in_funct3 = f3; in_rd = rd;
        in_alu_result = alu; in_mem_rdata = mem; in_pc_plus4 = pc;
        ill = (sel == 2'd1) && (f3 == 3'b111);
        val = (sel == 2'd0) ? alu : (sel == 2'd1) ? ref_load(f3, alu, mem) :
              (sel == 2'd2) ? pc : 64'd0;
        @(posedge clk);
        if (r) begin
            {m_v, m_rw, m_ill, m_rd, m_wd, m_ins} = '0;
        end else if (f) begin
            {m_v, m_rw, m_ill, m_rd, m_wd} = '0;
        end else if (!s) begin
            m_v   = v;
            m_ill = v && ill;
            m_rw  = v && rw && !ill && (sel != 2'd3) && (rd != 5'd0);
            m_rd  = rd;
            m_wd  = val;
            if (v) m_ins = m_ins + 64'd1;
        end
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic test_reset();
        step(1, 0, 0, 1, 1, 2'd0, 3'd0, 5'd9, 64'hDEAD, 64'hBEEF, 64'h44);
        step(1, 1, 1, 1, 1, 2'd2, 3'd0, 5'd9, 64'hDEAD, 64'hBEEF, 64'h44);
        checks++;
        if (dut_vec() !== 136'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", dut_vec());
        end
    endtask

    task automatic test_alu();
        step(0, 0, 0, 1, 1, 2'd0, 3'd0, 5'd5, 64'h1234, 64'h0, 64'h0);
        checks++;
        if ({RegWrite, WriteReg, WriteData, instret} !== {1'b1, 5'd5, 64'h1234, 64'd1}) begin
            errors++;
            $display("FAIL alu_capture got rw=%0b rd=%0d wd=%h ins=%0d exp rw=1 rd=5 wd=1234 ins=1",
                     RegWrite, WriteReg, WriteData, instret);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  f3s [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b110, 3'b011};
        logic [63:0] offs[6] = '{64'h1007, 64'h1007, 64'h1002, 64'h1004, 64'h1004, 64'h1005};
        logic [63:0] exps[6] = '{64'hFFFFFFFFFFFFFF88, 64'h88, 64'h4433,
                                 64'hFFFFFFFF88776655, 64'h88776655, 64'h8877665544332211};
        for (int i = 0; i < 6; i++) begin
            step(0, 0, 0, 1, 1, 2'd1, f3s[i], 5'd7, offs[i], 64'h8877665544332211, 64'h0);
            checks++;
            if (WriteData !== exps[i] || RegWrite !== 1'b1) begin
                errors++;
                $display("FAIL load_f3_%0d got wd=%h rw=%0b exp wd=%h rw=1",
                         f3s[i], WriteData, RegWrite, exps[i]);
            end
        end
    endtask

    task automatic test_x0_bubble();
        logic [63:0] ins0;
        ins0 = m_ins;
        step(0, 0, 0, 1, 1, 2'd0, 3'd0, 5'd0, 64'h55, 64'h0, 64'h0);
        checks++;
        if (RegWrite !== 1'b0 || wb_valid !== 1'b1 || instret !== ins0 + 64'd1) begin
            errors++;
            $display("FAIL x0_write got rw=%0b v=%0b ins=%0d exp rw=0 v=1 ins=%0d",
                     RegWrite, wb_valid, instret, ins0 + 64'd1);
        end
        step(0, 0, 0, 0, 1, 2'd0, 3'd0, 5'd6, 64'h66, 64'h0, 64'h0);
        checks++;
        if (RegWrite !== 1'b0 || wb_valid !== 1'b0 || instret !== ins0 + 64'd1) begin
            errors++;
            $display("FAIL bubble got rw=%0b v=%0b ins=%0d exp rw=0 v=0 ins=%0d",
                     RegWrite, wb_valid, instret, ins0 + 64'd1);
        end
    endtask

    task automatic test_stall_flush();
        logic [63:0] a, ins0;
        a = 64'hA5A5_0000_1111_2222;
        step(0, 0, 0, 1, 1, 2'd0, 3'd0, 5'd3, a, 64'h0, 64'h0);
        ins0 = m_ins;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 1, 1, 2'd2, 3'($urandom), 5'($urandom), rnd64(), rnd64(), rnd64());
            checks++;
            if ({RegWrite, WriteReg, WriteData, wb_valid, instret} !== {1'b1, 5'd3, a, 1'b1, ins0}) begin
                errors++;
                $display("FAIL stall_hold_%0d got rw=%0b rd=%0d wd=%h ins=%0d exp rw=1 rd=3 wd=%h ins=%0d",
                         i, RegWrite, WriteReg, WriteData, instret, a, ins0);
            end
        end
        step(0, 1, 1, 1, 1, 2'd0, 3'd0, 5'd4, 64'h77, 64'h0, 64'h0);
        checks++;
        if ({wb_valid, RegWrite, WriteReg, WriteData, instret} !== {2'b00, 5'd0, 64'd0, ins0}) begin
            errors++;
            $display("FAIL flush_with_stall got v=%0b rw=%0b rd=%0d wd=%h ins=%0d exp zeros ins=%0d",
                     wb_valid, RegWrite, WriteReg, WriteData, instret, ins0);
        end
        step(0, 0, 0, 1, 1, 2'd0, 3'd0, 5'd8, 64'h88, 64'h0, 64'h0);
        step(1, 0, 1, 1, 1, 2'd0, 3'd0, 5'd8, 64'h99, 64'h0, 64'h0);
        step(0, 0, 1, 1, 1, 2'd0, 3'd0, 5'd8, 64'h99, 64'h0, 64'h0);
        checks++;
        if (dut_vec() !== 136'd0) begin
            errors++;
            $display("FAIL reset_mid_stall got %h exp 0", dut_vec());
        end
    endtask

    task automatic test_link_illegal();
        step(0, 0, 0, 1, 1, 2'd2, 3'd0, 5'd1, 64'h10, 64'h20, 64'h80000008);
        checks++;
        if ({RegWrite, WriteReg, WriteData} !== {1'b1, 5'd1, 64'h80000008}) begin
            errors++;
            $display("FAIL link got rw=%0b rd=%0d wd=%h exp rw=1 rd=1 wd=80000008",
                     RegWrite, WriteReg, WriteData);
        end
        step(0, 0, 0, 1, 1, 2'd1, 3'b111, 5'd2, 64'h10, 64'hFFFF, 64'h0);
        checks++;
        if ({illegal_load, RegWrite, WriteData, wb_valid} !== {1'b1, 1'b0, 64'd0, 1'b1}) begin
            errors++;
            $display("FAIL illegal_load got ill=%0b rw=%0b wd=%h v=%0b exp ill=1 rw=0 wd=0 v=1",
                     illegal_load, RegWrite, WriteData, wb_valid);
        end
        step(0, 0, 0, 1, 1, 2'd3, 3'b111, 5'd2, 64'h10, 64'hFFFF, 64'h30);
        checks++;
        if ({illegal_load, RegWrite, WriteData} !== {1'b0, 1'b0, 64'd0}) begin
            errors++;
            $display("FAIL reserved_sel got ill=%0b rw=%0b wd=%h exp ill=0 rw=0 wd=0",
                     illegal_load, RegWrite, WriteData);
        end
    endtask

    task automatic test_wrap();
        step(1, 0, 0, 0, 0, 2'd0, 3'd0, 5'd0, 64'h0, 64'h0, 64'h0);
        for (int i = 1; i <= 17; i++) begin
            step(0, 0, 0, 1, 1, 2'd0, 3'd0, 5'd10, 64'(i), 64'h0, 64'h0);
            if (i >= 15) begin
                checks++;
                if (s_instret !== 4'(i % 16) || instret !== 64'(i)) begin
                    errors++;
                    $display("FAIL wrap_%0d got small=%0d wide=%0d exp small=%0d wide=%0d",
                             i, s_instret, instret, i % 16, i);
                end
            end
        end
    endtask

    task automatic test_random();
        logic r, f, s, v;
        logic [4:0]  rd;
        logic [63:0] ins_exp;
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) == 0);
            f  = ($urandom_range(0, 9) == 0);
            s  = ($urandom_range(0, 4) == 0);
            v  = ($urandom_range(0, 5) != 0);
            rd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            step(r, f, s, v, 1'($urandom), 2'($urandom), 3'($urandom), rd,
                 rnd64(), rnd64(), rnd64());
            ins_exp = m_ins;
            checks++;
            if (dut_vec() !== model_vec() || s_instret !== ins_exp[3:0]) begin
                errors++;
                $display("FAIL random_%0d got %h small=%0d exp %h small=%0d",
                         i, dut_vec(), s_instret, model_vec(), ins_exp[3:0]);
            end
        end
    endtask

    initial begin
        {rst, stall, flush, in_valid, in_RegWrite} = '0;
        in_result_sel = '0; in_funct3 = '0; in_rd = '0;
        in_alu_result = '0; in_mem_rdata = '0; in_pc_plus4 = '0;
        {m_v, m_rw, m_ill, m_rd, m_wd, m_ins} = '0;
        @(negedge clk);
        test_reset();
        test_alu();
        test_loads();
        test_x0_bubble();
        test_stall_flush();
        test_link_illegal();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register and writeback-select stage of the 64-bit RISC-V core.
- Captures memory-stage results each clock, extracts and extends load data, and selects the writeback value.
- Drives the register file write port (RegWrite, WriteReg, WriteData) from registered state, so the data is stable for a full cycle.
- Also maintains a retired-instruction counter.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- INSTRET_W, 64, width of the retired-instruction counter.

Ports:
- clk  input  1  core clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold all stage state this cycle
- flush  input  1  replace the captured instruction with a bubble
- in_valid  input  1  memory stage holds a real instruction
- in_RegWrite  input  1  instruction writes rd
- in_result_sel  input  2  0=ALU result, 1=load data, 2=PC+4, 3=reserved
- in_funct3  input  3  load size/sign code
- in_rd  input  5  destination register
- in_alu_result  input  64  ALU result, also load byte address
- in_mem_rdata  input  64  aligned 64-bit doubleword read from data memory
- in_pc_plus4  input  64  link value for JAL/JALR
- RegWrite  output  1  register-file write enable
- WriteReg  output  5  register-file destination
- WriteData  output  64  register-file write data
- wb_valid  output  1  stage holds a real instruction
- illegal_load  output  1  stage holds a load with funct3=111
- instret  output  64  count of retired instructions

Behaviour:
- Reset:
  - When rst=1 at a clock edge, all registers clear.
  - RegWrite=0, WriteReg=0, WriteData=0, wb_valid=0, illegal_load=0, instret=0.
- Update priority per edge is rst > flush > stall > capture.
  - flush: wb_valid, RegWrite and illegal_load clear. WriteReg/WriteData are don't-care but must be driven 0. instret unchanged.
  - stall (flush=0): every register holds, including instret. The register file rewrites the same value, which is idempotent.
  - capture: every register loads from the in_* inputs. Latency is exactly 1 cycle.
- Load extraction (combinational, on the input side before capture):
  - Byte offset off = in_alu_result[2:0].
  - 000 LB: byte mem_rdata[8*off+:8], sign-extended.
  - 100 LBU: same byte, zero-extended.
  - 001 LH: half at lane off[2:1], sign-extended.
  - 101 LHU: same half, zero-extended.
  - 010 LW: word at lane off[2], sign-extended.
  - 110 LWU: same word, zero-extended.
  - 011 LD: full 64 bits; off is ignored.
  - For LH/LW, low offset bits below the lane are ignored; there is no misalignment trap here.
  - 111: load data=0. illegal_load is captured as 1 and the captured RegWrite is forced 0.
- Writeback select:
  - sel 0 → alu_result; sel 1 → extracted load data; sel 2 → pc_plus4.
  - sel 3 → 0, with captured RegWrite forced 0.
  - illegal_load is only evaluated when sel=1.
- Output write enable:
  - RegWrite = wb_valid_q & RegWrite_q & (WriteReg_q != 0).
  - If in_valid=0 at capture, the stage captures a bubble: wb_valid=0 and RegWrite=0.
- instret:
  - Increments by 1 on every capture edge with in_valid=1 (no rst, no flush, no stall).
  - Wraps from 2^64−1 to 0.
- Simultaneous events:
  - flush together with stall: flush wins.
  - rst together with any other input: reset wins.
  - A reset asserted mid-stall clears the held instruction; no write occurs after the reset edge.

Test Plan:
- Reset/ALU path: rst for 2 cycles → all outputs 0. Then in_valid=1, sel=0, rd=5, alu=0x1234, RegWrite=1 → next cycle RegWrite=1, WriteReg=5, WriteData=0x1234, instret=1.
- Load extraction: mem_rdata=0x8877665544332211.
  - LB, off=7 → 0xFFFFFFFFFFFFFF88.
  - LBU, off=7 → 0x88.
  - LH, off=2 → 0x0000000000004433.
  - LW, off=4 → 0xFFFFFFFF88776655.
  - LWU, off=4 → 0x88776655.
  - LD → full value.
- x0 and bubbles: rd=0 with RegWrite=1 → RegWrite output 0 and instret still increments. in_valid=0 → wb_valid=0, RegWrite=0, instret unchanged.
- Stall/flush:
  - Capture rd=3 value A, then stall 3 cycles while inputs change → outputs hold A for 3 cycles, instret frozen.
  - Assert flush with stall → next cycle wb_valid=0, RegWrite=0.
- Link/illegal:
  - sel=2, pc_plus4=0x80000008, rd=1 → WriteData=0x80000008.
  - sel=1, funct3=111 → illegal_load=1, RegWrite=0, WriteData=0.
- Counter wrap: force instret to 0xFFFFFFFFFFFFFFFF via a long run or a bench backdoor, then one valid capture → instret=0.
